nram_fifo_ctrl: RTL and testbench

- Control stage placed directly upstream of the NRAM register bank and NMux read mux.
- Accepts a byte stream on a valid/ready port and writes each accepted byte into one bank register. It drives the bank's write data (io_Dbus) and one-hot write enables (io_ENbus).
- Drives the mux select (io_sel) and returns the mux output to a consumer on a valid/ready port.
- Together the three blocks form a DEPTH-entry FIFO.

---
 rtl/nram_fifo_ctrl_if.sv | 38 +++
 rtl/nram_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_nram_fifo_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nram_fifo_ctrl_if.sv
// Bus bundle between the FIFO controller, its producer/consumer and the NRAM bank + NMux.
// Pure wiring, no latency of its own.
// Backpressure travels on io_in_ready / io_out_ready like any valid/ready pair.
interface nram_fifo_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             io_flush;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_bits;
  logic [WIDTH-1:0] io_Dbus;
  logic [DEPTH-1:0] io_ENbus;
  logic [AW-1:0]    io_sel;
  logic [WIDTH-1:0] io_rdata;
  logic [CW-1:0]    io_count;
  logic             io_full;
  logic             io_empty;

  // Controller side.
  modport master (
    input  io_flush, io_in_valid, io_in_bits, io_out_ready, io_rdata,
    output io_in_ready, io_out_valid, io_out_bits, io_Dbus, io_ENbus,
           io_sel, io_count, io_full, io_empty
  );

  // Environment side: producer, consumer and the register bank / mux.
  modport slave (
    output io_flush, io_in_valid, io_in_bits, io_out_ready, io_rdata,
    input  io_in_ready, io_out_valid, io_out_bits, io_Dbus, io_ENbus,
           io_sel, io_count, io_full, io_empty
  );
endinterface

// File: rtl/nram_fifo_ctrl.sv
// Pointer/occupancy controller turning an external register bank + read mux into a DEPTH-entry FIFO.
// Write-to-read latency one cycle (no bypass on empty); ENbus/Dbus are combinational with the push.
// in_ready drops when full (even with a simultaneous pop), during flush and during reset.
module nram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  nram_fifo_ctrl_if.master bus
);

  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  logic [DEPTH-1:0] en_bus;

  // Explicit wrap so non-power-of-two depths step 0..DEPTH-1 correctly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake qualification: reset and flush both close the ports immediately.
  always_comb begin
    in_ready  = !reset && !bus.io_flush && (count_q != FULL_CNT);
    out_valid = !reset && !bus.io_flush && (count_q != '0);
    push      = bus.io_in_valid && in_ready;
    pop       = out_valid && bus.io_out_ready;
  end

  // One-hot write strobe into the bank slot addressed by the write pointer.
  always_comb begin
    en_bus = '0;
    if (push) begin
      en_bus = DEPTH'(1) << wptr_q;
    end
  end

  assign bus.io_in_ready  = in_ready;
  assign bus.io_out_valid = out_valid;
  assign bus.io_ENbus     = en_bus;
  assign bus.io_Dbus      = bus.io_in_bits;
  assign bus.io_sel       = rptr_q;
  assign bus.io_out_bits  = bus.io_rdata;
  assign bus.io_count     = count_q;
  assign bus.io_full      = (count_q == FULL_CNT);
  assign bus.io_empty     = (count_q == '0);

  // Next-state: flush wins, otherwise pointers advance per handshake and count tracks the net change.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.io_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers with asynchronous clear; an in-flight push is lost on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Pointer distance modulo DEPTH, used to cross-check the occupancy counter.
  logic [AW:0] ptr_dist;
  always_comb begin
    if (wptr_q >= rptr_q) begin
      ptr_dist = {1'b0, wptr_q} - {1'b0, rptr_q};
    end else begin
      ptr_dist = {1'b0, wptr_q} + DEPTH_EXT - {1'b0, rptr_q};
    end
  end

  a_en_onehot : assert property (@(posedge clk) $onehot0(bus.io_ENbus))
    else $error("ENbus not one-hot: %b", bus.io_ENbus);

  a_count_max : assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT)
    else $error("count exceeds DEPTH: %0d", count_q);

  a_count_ptr : assert property (@(posedge clk) disable iff (reset)
      ((count_q == FULL_CNT) && (wptr_q == rptr_q)) || ((AW + 1)'(count_q) == ptr_dist))
    else $error("count %0d inconsistent with pointers w=%0d r=%0d", count_q, wptr_q, rptr_q);

endmodule

// File: tb/tb_nram_fifo_ctrl.sv
// Directed bench: controller plus a behavioural register bank and read mux.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Each check is an immediate assertion that counts and reports its own failure.
module tb_nram_fifo_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  nram_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  nram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural NRAM bank and NMux.
  logic [WIDTH-1:0] bank [DEPTH];
  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.io_ENbus[i]) bank[i] <= bus.io_Dbus;
    end
  end
  assign bus.io_rdata = bank[bus.io_sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.io_flush     = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_in_bits   = 8'h5A;
    bus.io_out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready",  bus.io_in_ready, 0);
    check("rst_out_valid", bus.io_out_valid, 0);
    check("rst_enbus",     bus.io_ENbus, 0);
    check("rst_sel",       bus.io_sel, 0);
    check("rst_count",     bus.io_count, 0);
    check("rst_empty",     bus.io_empty, 1);
    check("rst_full",      bus.io_full, 0);
    check("rst_dbus",      bus.io_Dbus, 8'h5A);

    tick();
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", bus.io_in_ready, 1);

    // Push 0xA5 with consumer stalled
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = 8'hA5;
    #1;
    check("a5_enbus", bus.io_ENbus, 2'b01);
    check("a5_dbus",  bus.io_Dbus, 8'hA5);
    tick();
    bus.io_in_valid = 1'b0;
    #1;
    check("a5_count",     bus.io_count, 1);
    check("a5_out_valid", bus.io_out_valid, 1);
    check("a5_sel",       bus.io_sel, 0);
    check("a5_out_bits",  bus.io_out_bits, 8'hA5);
    check("a5_empty",     bus.io_empty, 0);

    // Drain it so the fill test starts empty
    bus.io_out_ready = 1'b1;
    tick();
    bus.io_out_ready = 1'b0;
    #1;
    check("drain_a5_count", bus.io_count, 0);
    check("drain_a5_valid", bus.io_out_valid, 0);

    // Fill: 0x11 -> slot 1, 0x22 -> slot 0
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = 8'h11;
    #1;
    check("p11_enbus", bus.io_ENbus, 2'b10);
    tick();
    bus.io_in_bits = 8'h22;
    #1;
    check("p22_enbus", bus.io_ENbus, 2'b01);
    tick();
    bus.io_in_bits = 8'h33;
    #1;
    check("full_flag",     bus.io_full, 1);
    check("full_in_ready", bus.io_in_ready, 0);
    check("full_count",    bus.io_count, 2);
    check("full_enbus",    bus.io_ENbus, 2'b00);
    check("full_head",     bus.io_out_bits, 8'h11);
    check("full_sel",      bus.io_sel, 1);
    tick();
    check("held_count", bus.io_count, 2);

    // Pop from full with push pending: only the pop happens
    bus.io_out_ready = 1'b1;
    #1;
    check("fullpop_enbus", bus.io_ENbus, 2'b00);
    tick();
    bus.io_out_ready = 1'b0;
    #1;
    check("fullpop_count", bus.io_count, 1);
    check("fullpop_sel",   bus.io_sel, 0);
    check("fullpop_head",  bus.io_out_bits, 8'h22);
    check("p33_enbus",     bus.io_ENbus, 2'b10);
    tick();
    bus.io_in_valid = 1'b0;
    #1;
    check("p33_count", bus.io_count, 2);

    // Drain 0x22, 0x33
    bus.io_out_ready = 1'b1;
    #1;
    check("drain_22", bus.io_out_bits, 8'h22);
    tick();
    check("drain_33", bus.io_out_bits, 8'h33);
    check("drain_33_sel", bus.io_sel, 1);
    tick();
    check("drained_empty", bus.io_empty, 1);

    // Steady stream 0x01..0x08 with consumer always ready; wptr starts at 0
    for (int i = 0; i < 8; i++) begin
      bus.io_in_valid = 1'b1;
      bus.io_in_bits  = 8'(i + 1);
      #1;
      check("stream_enbus", bus.io_ENbus, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        check("stream_out",   bus.io_out_bits, i);
        check("stream_count", bus.io_count, 1);
      end
      tick();
    end
    bus.io_in_valid = 1'b0;
    #1;
    check("stream_last", bus.io_out_bits, 8'h08);
    check("stream_last_count", bus.io_count, 1);
    tick();
    bus.io_out_ready = 1'b0;
    check("stream_done_empty", bus.io_empty, 1);

    // Flush from count=2 with push and pop both requested
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = 8'hC1;
    tick();
    bus.io_in_bits  = 8'hC2;
    tick();
    check("preflush_count", bus.io_count, 2);
    bus.io_flush     = 1'b1;
    bus.io_out_ready = 1'b1;
    bus.io_in_bits   = 8'hC3;
    #1;
    check("flush_enbus",     bus.io_ENbus, 2'b00);
    check("flush_out_valid", bus.io_out_valid, 0);
    check("flush_in_ready",  bus.io_in_ready, 0);
    tick();
    bus.io_flush     = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_out_ready = 1'b0;
    #1;
    check("postflush_count", bus.io_count, 0);
    check("postflush_empty", bus.io_empty, 1);
    check("postflush_valid", bus.io_out_valid, 0);
    check("postflush_sel",   bus.io_sel, 0);
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = 8'h44;
    #1;
    check("postflush_enbus", bus.io_ENbus, 2'b01);
    tick();
    bus.io_in_valid = 1'b0;
    #1;
    check("postflush_push_count", bus.io_count, 1);

    // Asynchronous reset between edges with a push in flight
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = 8'h77;
    #1;
    check("prerst_enbus", bus.io_ENbus, 2'b10);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_in_ready",  bus.io_in_ready, 0);
    check("midrst_out_valid", bus.io_out_valid, 0);
    check("midrst_enbus",     bus.io_ENbus, 2'b00);
    check("midrst_count",     bus.io_count, 0);
    tick();
    reset = 1'b0;
    bus.io_in_bits = 8'h99;
    #1;
    check("relrst_enbus", bus.io_ENbus, 2'b01);
    tick();
    bus.io_in_valid = 1'b0;
    #1;
    check("relrst_count", bus.io_count, 1);
    check("relrst_out",   bus.io_out_bits, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred ns long.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
